// File: rtl/mult_pkg.sv
// Shared types and defaults for the add-shift signed multiplier sequencer.
package mult_pkg;

  localparam int MULT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ADD     = 3'd2,
    SHIFT   = 3'd3,
    HOLD    = 3'd4,
    LDB     = 3'd5,
    WAITREL = 3'd6
  } mult_state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous push-button level.
module btn_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the raw button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  assign dout = sync_r;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the 8-bit add-shift signed multiplier datapath.
// Optional MULT_BTN_SYNC_EN routes Run/CALB through 2-flop synchronizers.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             CALB,
  input  logic             M,
  output logic             LoadA,
  output logic             LoadB,
  output logic             ClrAX,
  output logic             Add,
  output logic             Sub,
  output logic             Shift_En,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Iter
);

  localparam logic [CNT_W-1:0] ITER_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

  mult_state_t      state_r;
  mult_state_t      state_s;
  logic [CNT_W-1:0] iter_r;
  logic [CNT_W-1:0] iter_s;
  logic             run_s;
  logic             calb_s;

`ifdef MULT_BTN_SYNC_EN
  btn_sync #(.RST_VAL(1'b1)) u_run_sync (
    .clk   (Clk),
    .rst_n (Reset),
    .din   (Run),
    .dout  (run_s)
  );

  btn_sync #(.RST_VAL(1'b1)) u_calb_sync (
    .clk   (Clk),
    .rst_n (Reset),
    .din   (CALB),
    .dout  (calb_s)
  );
`else
  assign run_s  = Run;
  assign calb_s = CALB;
`endif

  // State and iteration counter registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      iter_r  <= '0;
    end else begin
      state_r <= state_s;
      iter_r  <= iter_s;
    end
  end

  // Next-state and counter update; Run wins over CALB when both are pressed.
  always_comb begin
    state_s = state_r;
    iter_s  = iter_r;
    case (state_r)
      IDLE: begin
        if (!run_s) begin
          state_s = CLEAR;
        end else if (!calb_s) begin
          state_s = LDB;
        end else begin
          state_s = IDLE;
        end
      end
      LDB:     state_s = WAITREL;
      WAITREL: begin
        if (calb_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAITREL;
        end
      end
      CLEAR: begin
        iter_s  = '0;
        state_s = ADD;
      end
      ADD:     state_s = SHIFT;
      SHIFT: begin
        // Counter saturates so a corrupted state can never wrap it.
        if (iter_r == ITER_MAX) begin
          iter_s = iter_r;
        end else begin
          iter_s = iter_r + CNT_W'(1);
        end
        if (iter_r >= ITER_LAST) begin
          state_s = HOLD;
        end else begin
          state_s = ADD;
        end
      end
      HOLD: begin
        if (run_s) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
        iter_s  = '0;
      end
    endcase
  end

  // Moore decode of the state register; only the ADD strobes look at M.
  always_comb begin
    LoadA    = 1'b0;
    LoadB    = 1'b0;
    ClrAX    = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_r)
      IDLE, WAITREL: begin
        Busy = 1'b0;
      end
      LDB: begin
        LoadB = 1'b1;
        ClrAX = 1'b1;
      end
      CLEAR: begin
        ClrAX = 1'b1;
        Busy  = 1'b1;
      end
      ADD: begin
        Busy  = 1'b1;
        LoadA = M;
        if (iter_r == ITER_LAST) begin
          Sub = M;
        end else begin
          Add = M;
        end
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
      end
      HOLD: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

  assign Iter = iter_r;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a behavioural multiplier datapath.
module tb_mult_seq_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;
`ifdef MULT_BTN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset_n, run, calb, m;
  logic loada, loadb, clrax, add, sub, shift_en, busy, done;
  logic [CW-1:0] iter;

  logic [1:0] m_mode;
  logic [7:0] a_r, b_r, s_r;
  logic       x_r;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_no, cnt_loada, cnt_add, cnt_sub, cnt_both, sub_at, cnt_shift;
  int cnt_clr, cnt_ldb, cnt_done, first_done, iter_max, iter_at_done;

  always #5 clk = ~clk;

  assign m = (m_mode == 2'd2) ? b_r[0] : m_mode[0];

  mult_seq_ctrl dut (
    .Clk      (clk),
    .Reset    (reset_n),
    .Run      (run),
    .CALB     (calb),
    .M        (m),
    .LoadA    (loada),
    .LoadB    (loadb),
    .ClrAX    (clrax),
    .Add      (add),
    .Sub      (sub),
    .Shift_En (shift_en),
    .Busy     (busy),
    .Done     (done),
    .Iter     (iter)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    tick_no = 0; cnt_loada = 0; cnt_add = 0; cnt_sub = 0; cnt_both = 0; sub_at = 0;
    cnt_shift = 0; cnt_clr = 0; cnt_ldb = 0; cnt_done = 0; first_done = 0;
    iter_max = 0; iter_at_done = -1;
  endtask

  // Observe one cycle at the falling edge and advance the datapath model.
  task automatic tick();
    logic [8:0] sum9;
    logic [7:0] a_n, b_n;
    logic       x_n;
    @(negedge clk);
    tick_no++;
    if (loada) begin
      cnt_loada++;
      if (sub) sub_at = cnt_loada;
    end
    if (add) cnt_add++;
    if (sub) cnt_sub++;
    if (add && sub) cnt_both++;
    if (shift_en) cnt_shift++;
    if (clrax) cnt_clr++;
    if (loadb) cnt_ldb++;
    if (done) begin
      cnt_done++;
      if (first_done == 0) begin
        first_done   = tick_no;
        iter_at_done = int'(iter);
      end
    end
    if (int'(iter) > iter_max) iter_max = int'(iter);
    sum9 = {a_r[7], a_r};
    if (add) sum9 = sum9 + {s_r[7], s_r};
    if (sub) sum9 = sum9 - {s_r[7], s_r};
    a_n = a_r; b_n = b_r; x_n = x_r;
    if (clrax) begin
      a_n = 8'h00; x_n = 1'b0;
    end else if (loada) begin
      a_n = sum9[7:0]; x_n = sum9[8];
    end else if (shift_en) begin
      a_n = {x_r, a_r[7:1]};
    end
    if (loadb) b_n = s_r;
    else if (shift_en) b_n = {a_r[0], b_r[7:1]};
    a_r = a_n; b_r = b_n; x_r = x_n;
  endtask

  // Press Run for 'hold' cycles and follow the operation until Done drops.
  task automatic run_op(input int hold);
    int ok;
    clr_cnt();
    ok  = 0;
    run = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (tick_no >= hold) run = 1'b1;
      if (first_done > 0 && !done && tick_no >= hold) begin
        ok = 1;
        break;
      end
    end
    run = 1'b1;
    check_eq("op_complete", ok, 1);
  endtask

  task automatic calb_load(input logic [7:0] val, input int hold);
    s_r  = val;
    calb = 1'b0;
    repeat (hold) tick();
    calb = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    int found;
    int prod;
    logic [7:0] av, bv;
    reset_n = 1'b0; run = 1'b1; calb = 1'b1; m_mode = 2'd1;
    a_r = 8'h00; b_r = 8'h00; s_r = 8'h00; x_r = 1'b0;
    clr_cnt();
    #2;
    check_eq("reset_outputs", int'({loada, loadb, clrax, add, sub, shift_en, busy, done}), 0);
    check_eq("reset_iter", int'(iter), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // M tied 1, short press
    m_mode = 2'd1;
    run_op(3);
    check_eq("t1_loada", cnt_loada, W);
    check_eq("t1_add", cnt_add, W - 1);
    check_eq("t1_sub", cnt_sub, 1);
    check_eq("t1_sub_last", sub_at, W);
    check_eq("t1_add_sub_both", cnt_both, 0);
    check_eq("t1_shift", cnt_shift, W);
    check_eq("t1_done_latency", first_done, LAT + 2 * W + 1);
    check_eq("t1_done_cycles", cnt_done, 1);
    check_eq("t1_iter_at_done", iter_at_done, W);
    check_eq("t1_clr", cnt_clr, 1);

    // M tied 0
    m_mode = 2'd0;
    run_op(2);
    check_eq("t2_loada", cnt_loada, 0);
    check_eq("t2_addsub", cnt_add + cnt_sub, 0);
    check_eq("t2_shift", cnt_shift, W);
    check_eq("t2_iter_max", iter_max, W);

    // Run held for 100 cycles: single operation, Done held until release
    m_mode = 2'd1;
    run_op(100);
    check_eq("t3_clr_once", cnt_clr, 1);
    check_eq("t3_shift", cnt_shift, W);
    check_eq("t3_done_cycles", cnt_done, 101 - (LAT + 2 * W + 1) + (LAT - 1));
    repeat (5) tick();
    check_eq("t3_idle_after", int'({busy, done}), 0);

    // CALB held 20 cycles: one load/clear pulse
    clr_cnt();
    calb_load(8'h11, 20);
    check_eq("t4_loadb_once", cnt_ldb, 1);
    check_eq("t4_clrax_once", cnt_clr, 1);
    check_eq("t4_busy_never", cnt_shift, 0);

    // Run and CALB together: CLEAR wins, CALB ignored in HOLD
    clr_cnt();
    run = 1'b0; calb = 1'b0;
    repeat (LAT) tick();
    check_eq("t4_both_clear", int'({busy, clrax, loadb}), 6);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) begin found = 1; break; end
    end
    check_eq("t4_both_done", found, 1);
    repeat (4) tick();
    run = 1'b1; calb = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!done) begin found = 1; break; end
    end
    check_eq("t4_both_release", found, 1);
    repeat (4) tick();
    check_eq("t4_no_loadb", cnt_ldb, 0);

    // Reset in the middle of an operation
    m_mode = 2'd1;
    clr_cnt();
    run = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (int'(iter) == 3 && loada) begin found = 1; break; end
    end
    check_eq("t5_reach_iter3", found, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_async_outputs", int'({loada, loadb, clrax, add, sub, shift_en, busy, done}), 0);
    check_eq("t5_async_iter", int'(iter), 0);
    run = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    clr_cnt();
    repeat (5) tick();
    check_eq("t5_idle_after", cnt_clr + cnt_shift + cnt_done + cnt_ldb, 0);

    // Datapath: 7 x -3
    m_mode = 2'd2;
    calb_load(8'h07, 3);
    s_r = 8'hFD;
    run_op(4);
    check_eq("t6_product", int'({a_r, b_r}), 16'hFFEB);
    check_eq("t6_x", int'(x_r), 1);

    // Random signed products
    for (int k = 0; k < 10; k++) begin
      bv = 8'($urandom_range(0, 255));
      av = 8'($urandom_range(0, 255));
      calb_load(bv, $urandom_range(1, 6));
      s_r = av;
      run_op($urandom_range(1, 30));
      prod = int'($signed(av)) * int'($signed(bv));
      check_eq("rnd_product", int'({a_r, b_r}), int'(prod[15:0]));
      check_eq("rnd_x", int'(x_r), int'(prod[15]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
